mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_if.sv | 30 +++
 rtl/mux_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Bundle of button, mux and status signals between the scan controller and
// its surroundings.
//   btnC/btnU/btnL/btnR : raw push buttons (scan toggle, step up, step down, one-shot sweep)
//   mux_in              : output of the external 16:1 mux addressed by sel
//   sel                 : registered mux select
//   frame / led         : last completed sweep, frame[i] = mux_in sampled with sel=i
//   frame_valid         : one-cycle pulse when frame updates
//   busy                : high while a sweep is running
interface mux_scan_if;
  logic        btnC;
  logic        btnU;
  logic        btnL;
  logic        btnR;
  logic        mux_in;
  logic [3:0]  sel;
  logic [15:0] frame;
  logic        frame_valid;
  logic        busy;
  logic [15:0] led;

  modport master (
    output btnC, btnU, btnL, btnR, mux_in,
    input  sel, frame, frame_valid, busy, led
  );

  modport slave (
    input  btnC, btnU, btnL, btnR, mux_in,
    output sel, frame, frame_valid, busy, led
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 16:1 mux. Buttons are synchronised and
// debounced into single-cycle press pulses; an FSM steps sel manually or
// sweeps all 16 channels, sampling mux_in after a settle time and holding
// each channel for a dwell time before moving on.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mux_scan_if slave (buttons and mux_in in; sel, frame, frame_valid, busy, led out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_MANUAL  | idle; btnU/btnL step sel, btnR starts one-shot, btnC continuous
// ST_SETTLE  | sel held while mux output settles; samples mux_in on timeout
// ST_DWELL   | hold after the sample; then next channel or frame complete
module mux_scan_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DWELL_CYCLES    = 3
) (
  input logic       clk,
  input logic       rst_n,
  mux_scan_if.slave bus
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] D_LOAD = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] S_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] W_LOAD = TW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  // Button index: 0 = C, 1 = U, 2 = L, 3 = R
  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q, sync2_q, deb_q, press_q;
  logic [DW-1:0] dcnt_q [4];

  assign btn_raw = {bus.btnR, bus.btnL, bus.btnU, bus.btnC};

  // Down-counter reloads while the synchronised level matches the accepted
  // level; reaching zero with a still-differing level accepts it. A press
  // pulse is raised only on acceptance of a high level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 4; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= D_LOAD;
        end else if (dcnt_q[i] == '0) begin
          deb_q[i]   <= sync2_q[i];
          press_q[i] <= sync2_q[i];
          dcnt_q[i]  <= D_LOAD;
        end else begin
          dcnt_q[i] <= dcnt_q[i] - 1'b1;
        end
      end
    end
  end

  state_t        state_q, state_d;
  logic          cont_q, cont_d;
  logic [3:0]    sel_q, sel_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   frame_q, frame_d;
  logic          fv_q, fv_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_MANUAL;
      cont_q   <= 1'b0;
      sel_q    <= '0;
      tcnt_q   <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cont_q   <= cont_d;
      sel_q    <= sel_d;
      tcnt_q   <= tcnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cont_d   = cont_q;
    sel_d    = sel_q;
    tcnt_d   = tcnt_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        // btnC takes priority over btnR; a start beats any step request
        if (press_q[0]) begin
          cont_d  = 1'b1;
          sel_d   = '0;
          tcnt_d  = S_LOAD;
          state_d = ST_SETTLE;
        end else if (press_q[3]) begin
          cont_d  = 1'b0;
          sel_d   = '0;
          tcnt_d  = S_LOAD;
          state_d = ST_SETTLE;
        end else if (press_q[1] && !press_q[2]) begin
          sel_d = sel_q + 4'd1;
        end else if (press_q[2] && !press_q[1]) begin
          sel_d = sel_q - 4'd1;
        end
      end
      ST_SETTLE: begin
        if (press_q[0]) begin
          state_d  = ST_MANUAL;
          cont_d   = 1'b0;
          shadow_d = '0;
          tcnt_d   = '0;
        end else if (tcnt_q == '0) begin
          shadow_d[sel_q] = bus.mux_in;
          tcnt_d          = W_LOAD;
          state_d         = ST_DWELL;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      ST_DWELL: begin
        if (press_q[0]) begin
          state_d  = ST_MANUAL;
          cont_d   = 1'b0;
          shadow_d = '0;
          tcnt_d   = '0;
        end else if (tcnt_q == '0) begin
          if (sel_q != 4'd15) begin
            sel_d   = sel_q + 4'd1;
            tcnt_d  = S_LOAD;
            state_d = ST_SETTLE;
          end else begin
            frame_d = shadow_q;
            fv_d    = 1'b1;
            sel_d   = '0;
            tcnt_d  = cont_q ? S_LOAD : '0;
            state_d = cont_q ? ST_SETTLE : ST_MANUAL;
          end
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_MANUAL;
        cont_d  = 1'b0;
        tcnt_d  = '0;
      end
    endcase
  end

  assign bus.sel         = sel_q;
  assign bus.frame       = frame_q;
  assign bus.led         = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.busy        = (state_q != ST_MANUAL);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl with DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2,
// DWELL_CYCLES=3. A behavioural model (sweep position arithmetic plus a
// sample-history debouncer) is compared against the DUT every cycle, and
// directed scenarios add literal expectations.
module tb_mux_scan_ctrl;
  localparam int D   = 4;
  localparam int S   = 2;
  localparam int W   = 3;
  localparam int PER = S + W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  btn;
  logic [15:0] pattern;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fv_count = 0;

  mux_scan_if bus ();

  assign bus.btnC   = btn[0];
  assign bus.btnU   = btn[1];
  assign bus.btnL   = btn[2];
  assign bus.btnR   = btn[3];
  assign bus.mux_in = pattern[bus.sel];

  mux_scan_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SETTLE_CYCLES  (S),
    .DWELL_CYCLES   (W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [3:0]   m_s1, m_s2, m_deb, m_press, m_p;
  bit [D-1:0] m_hist [4];
  bit         m_sweep, m_cont, m_fv, model_live;
  int         m_k, m_sel;
  bit [15:0]  m_frame, m_shadow;

  initial begin
    model_live = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_press = '0;
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
        m_sweep = 0; m_cont = 0; m_fv = 0; m_k = 0; m_sel = 0;
        m_frame = '0; m_shadow = '0;
        model_live = 1'b1;
      end else begin
        m_p  = m_press;
        m_fv = 0;
        if (!m_sweep) begin
          if (m_p[0] || m_p[3]) begin
            m_cont  = m_p[0];
            m_sweep = 1;
            m_k     = 0;
            m_sel   = 0;
          end else if (m_p[1] && !m_p[2]) begin
            m_sel = (m_sel + 1) % 16;
          end else if (m_p[2] && !m_p[1]) begin
            m_sel = (m_sel + 15) % 16;
          end
        end else if (m_p[0]) begin
          m_sweep = 0;
          m_cont  = 0;
        end else begin
          if (m_k % PER == S - 1) m_shadow[m_k / PER] = pattern[m_sel];
          if (m_k == 16 * PER - 1) begin
            m_frame = m_shadow;
            m_fv    = 1;
            m_k     = 0;
            m_sweep = m_cont;
          end else begin
            m_k++;
          end
          m_sel = m_k / PER;
        end
        for (int i = 0; i < 4; i++) begin
          m_hist[i]  = {m_hist[i][D-2:0], m_s2[i]};
          m_press[i] = 0;
          if (m_hist[i] == '1 && !m_deb[i]) begin
            m_deb[i]   = 1;
            m_press[i] = 1;
          end else if (m_hist[i] == '0 && m_deb[i]) begin
            m_deb[i] = 0;
          end
        end
        m_s2 = m_s1;
        m_s1 = btn;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("sel",         32'(bus.sel),         32'(m_sel));
        chk("busy",        32'(bus.busy),        32'(m_sweep));
        chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
        chk("frame",       32'(bus.frame),       32'(m_frame));
        chk("led",         32'(bus.led),         32'(m_frame));
        if (bus.frame_valid) fv_count++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  localparam int P_BUSY = 0, P_FV = 1, P_SEL = 2;

  function automatic int probe(input int what);
    case (what)
      P_BUSY:  return int'(bus.busy);
      P_FV:    return int'(bus.frame_valid);
      default: return int'(bus.sel);
    endcase
  endfunction

  task automatic wait_for(input string nm, input int what, input int val,
                          input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (probe(what) == val) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout %s: value %0d not seen within %0d cycles", nm, val, budget);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_mask(input logic [3:0] m);
    tick(1);
    btn = m;
    tick(10);
    btn = '0;
    tick(8);
  endtask

  int c0, tb0, tf, tf1, tf2, ts, fvc;

  initial begin
    btn = '0; pattern = '0; rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sel",   32'(bus.sel), 32'd0);
    chk("rst_frame", 32'(bus.frame), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);

    // manual stepping
    for (int i = 0; i < 16; i++) begin
      press_mask(4'b0010);
      chk("step_up", 32'(bus.sel), 32'((i + 1) % 16));
    end
    press_mask(4'b0100);
    chk("step_down_wrap", 32'(bus.sel), 32'd15);
    press_mask(4'b0110);
    chk("up_down_same", 32'(bus.sel), 32'd15);

    // one-shot sweep
    tick(1);
    pattern = 16'hA5C3;
    c0 = cyc;
    btn[3] = 1'b1;
    wait_for("oneshot_busy", P_BUSY, 1, 20, tb0);
    chk("start_latency_in_window", 32'((tb0 - c0 >= D + 3) && (tb0 - c0 <= D + 5)), 32'd1);
    tick(1);
    btn[3] = 1'b0;
    wait_for("oneshot_fv", P_FV, 1, 200, tf);
    chk("oneshot_period", 32'(tf - tb0), 32'd80);
    chk("oneshot_frame",  32'(bus.frame), 32'h0000A5C3);
    chk("oneshot_led",    32'(bus.led),   32'h0000A5C3);
    chk("oneshot_sel",    32'(bus.sel),   32'd0);
    chk("oneshot_idle",   32'(bus.busy),  32'd0);

    // continuous sweep, pattern change between frames
    tick(10);
    pattern = 16'h1234;
    btn[0] = 1'b1;
    wait_for("cont_busy", P_BUSY, 1, 20, tb0);
    tick(1);
    btn[0] = 1'b0;
    wait_for("cont_fv1", P_FV, 1, 200, tf1);
    chk("cont_frame1", 32'(bus.frame), 32'h00001234);
    chk("cont_busy1",  32'(bus.busy),  32'd1);
    pattern = 16'hFFFF;
    wait_for("cont_fv2", P_FV, 1, 200, tf2);
    chk("cont_period", 32'(tf2 - tf1), 32'd80);
    chk("cont_frame2", 32'(bus.frame), 32'h0000FFFF);
    chk("cont_busy2",  32'(bus.busy),  32'd1);

    // abort with btnC at sel=7
    pattern = 16'h1234;
    wait_for("cont_fv3", P_FV, 1, 200, tf);
    chk("cont_frame3", 32'(bus.frame), 32'h00001234);
    fvc = fv_count;
    wait_for("sel6", P_SEL, 6, 100, ts);
    tick(1);
    btn[0] = 1'b1;
    tick(10);
    btn[0] = 1'b0;
    wait_for("abort_idle", P_BUSY, 0, 20, ts);
    chk("abort_sel",   32'(bus.sel),   32'd7);
    chk("abort_frame", 32'(bus.frame), 32'h00001234);
    tick(20);
    chk("abort_no_fv", 32'(fv_count - fvc), 32'd0);
    chk("abort_sel_hold", 32'(bus.sel), 32'd7);

    // reset mid-sweep at sel=9
    tick(1);
    btn[3] = 1'b1;
    wait_for("rst_sweep_busy", P_BUSY, 1, 20, tb0);
    tick(1);
    btn[3] = 1'b0;
    wait_for("sel9", P_SEL, 9, 100, ts);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_sel",   32'(bus.sel),         32'd0);
    chk("midrst_frame", 32'(bus.frame),       32'd0);
    chk("midrst_busy",  32'(bus.busy),        32'd0);
    chk("midrst_fv",    32'(bus.frame_valid), 32'd0);

    // button held through reset release
    tick(1);
    btn[1] = 1'b1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    c0 = cyc;
    wait_for("held_rst_step", P_SEL, 1, 30, ts);
    chk("held_rst_latency_in_window", 32'((ts - c0 >= D + 3) && (ts - c0 <= D + 5)), 32'd1);
    tick(1);
    btn[1] = 1'b0;
    tick(10);

    // glitch rejection, then a genuine press
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    tick(15);
    chk("glitch_no_step", 32'(bus.sel), 32'd1);
    btn[1] = 1'b1;
    tick(10);
    btn[1] = 1'b0;
    tick(8);
    chk("held_one_step", 32'(bus.sel), 32'd2);

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
